div_sched: RTL and testbench

Round-robin scheduler sharing one 400-bit / 8-bit long divider among N_REQ requesters. It latches a winner's operands and holds them stable on the divider inputs for the whole operation. It pulses the divider start, waits for done, and returns the quotient with a one-cycle ack to the winner. It sits between the requesters and the single divider instance and is the only driver of the divider's start and operand inputs.

---
 rtl/div_sched_pkg.sv | 16 +
 rtl/div_sched_rr_arbiter.sv | 28 ++
 rtl/div_sched.sv | 146 ++++++++++++++
 tb/tb_div_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the div_sched divider scheduler.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned DW_DEF      = 400;
  localparam int unsigned VW_DEF      = 8;
  // Cycles from the request sample to the first div_done
  localparam int unsigned DIV_LATENCY = 52;

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, search starts at rr_ptr+1.
module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = PW'((32'(rr_ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one long divider among N_REQ requesters.
// Define DIV_SCHED_TIMEOUT_EN to add the BUSY watchdog and sticky fault.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned VW      = VW_DEF,
  parameter int unsigned TIMEOUT = 127
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_dividend,
  input  logic [N_REQ*VW-1:0] req_divisor,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       resp_quotient,
  output logic                resp_err,
  output logic                busy,
  output logic                fault,
  output logic                div_start,
  output logic [DW-1:0]       div_dividend,
  output logic [VW-1:0]       div_divisor,
  input  logic [DW-1:0]       div_quotient,
  input  logic                div_done
);

  localparam int unsigned PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_range
    $error("div_sched: N_REQ must be 2..8 and TIMEOUT 1..255");
  end

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     id;
  logic [PW-1:0]     win_id;
  logic [N_REQ-1:0]  grant;
  logic [DW-1:0]     win_dvd;
  logic [VW-1:0]     win_dvs;
  logic              settle;
  logic              fault_q;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req   (req),
    .rr_ptr(rr_ptr),
    .grant (grant)
  );

  always_comb begin
    win_id  = '0;
    win_dvd = '0;
    win_dvs = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_id  = PW'(i);
        win_dvd = req_dividend[i*DW +: DW];
        win_dvs = req_divisor[i*VW +: VW];
      end
    end
  end

  always_comb begin
    ack = '0;
    if (state == RESP) ack[id] = 1'b1;
  end

  assign busy      = (state != IDLE);
  assign div_start = (state == ISSUE);
  assign fault     = fault_q;

`ifdef DIV_SCHED_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_fire;

  assign to_fire = (to_cnt == 8'(TIMEOUT));

  // The divider cannot be aborted, so the fault stays until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state == ISSUE)     to_cnt <= '0;
      else if (state == BUSY) to_cnt <= to_cnt + 8'd1;
      if (state == BUSY && !div_done && to_fire) fault_q <= 1'b1;
    end
  end
`else
  assign fault_q = 1'b0;
`endif

  // settle holds off the grant for one IDLE cycle after every response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= PW'(N_REQ - 1);
      id            <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      resp_quotient <= '0;
      resp_err      <= 1'b0;
      settle        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          settle <= 1'b0;
          if (!settle && !fault_q && |grant) begin
            id           <= win_id;
            div_dividend <= win_dvd;
            div_divisor  <= win_dvs;
            if (win_dvs == '0) begin
              resp_quotient <= '0;
              resp_err      <= 1'b1;
              state         <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= BUSY;
        BUSY: begin
          if (div_done) begin
            resp_quotient <= div_quotient;
            resp_err      <= 1'b0;
            state         <= RESP;
          end
`ifdef DIV_SCHED_TIMEOUT_EN
          else if (to_fire) begin
            resp_quotient <= '0;
            resp_err      <= 1'b1;
            state         <= RESP;
          end
`endif
        end
        RESP: begin
          rr_ptr <= id;
          settle <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: divider model, timeline-level reference model, directed and random traffic.
`timescale 1ns/1ps
module tb_div_sched;
  import div_sched_pkg::*;

  localparam int unsigned N       = 4;
  localparam int unsigned DW      = DW_DEF;
  localparam int unsigned VW      = VW_DEF;
  localparam int unsigned TIMEOUT = 127;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req;
  logic [DW-1:0]   dvd_v [N];
  logic [VW-1:0]   dvs_v [N];
  logic [N*DW-1:0] req_dividend;
  logic [N*VW-1:0] req_divisor;
  logic [N-1:0]    ack;
  logic [DW-1:0]   resp_quotient;
  logic            resp_err, busy, fault, div_start;
  logic [DW-1:0]   div_dividend;
  logic [VW-1:0]   div_divisor;
  logic [DW-1:0]   div_quotient = '0;
  logic            div_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start = 0;

  div_sched #(.N_REQ(N), .DW(DW), .VW(VW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .ack          (ack),
    .resp_quotient(resp_quotient),
    .resp_err     (resp_err),
    .busy         (busy),
    .fault        (fault),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_done     (div_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (div_start) n_start++;

  always_comb begin
    req_dividend = '0;
    req_divisor  = '0;
    for (int i = 0; i < N; i++) begin
      req_dividend[i*DW +: DW] = dvd_v[i];
      req_divisor[i*VW +: VW]  = dvs_v[i];
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Divider: 50 working cycles after the start edge, then done (level) with the quotient.
  logic    div_hang = 1'b0;
  int      dcnt = 0;
  logic [DW-1:0] dcap;
  logic [VW-1:0] vcap;
  always @(posedge clk) begin
    if (div_start) begin
      dcnt     <= 50;
      div_done <= 1'b0;
      dcap     <= div_dividend;
      vcap     <= div_divisor;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !div_hang) begin
        div_done     <= 1'b1;
        div_quotient <= (vcap == '0) ? '0 : dcap / DW'(vcap);
      end
    end
  end

  // Reference model: per-transaction timeline (sample, start, ack cycles) plus held response registers.
  bit            m_active, m_err, m_to, m_fault;
  int            m_w, m_samp, m_ack, m_start, m_last, m_next;
  logic [DW-1:0] m_q, e_q, e_dvd, p_dvd;
  logic [VW-1:0] e_dvs, p_dvs;
  bit            e_err;

  always @(negedge clk) begin
    logic [N-1:0] e_ack;
    bit           e_busy, e_start;
    int           w, c;
    e_ack = '0; e_busy = 0; e_start = 0;
    if (rst) begin
      m_active = 0; m_last = N - 1; m_next = 0; m_fault = 0;
      e_q = '0; e_err = 0; e_dvd = '0; e_dvs = '0;
    end else begin
      if (!m_active && !m_fault && cyc >= m_next && req != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (w < 0 && req[c]) w = c;
        end
        m_active = 1; m_w = w; m_samp = cyc; m_to = 0;
        p_dvd = dvd_v[w]; p_dvs = dvs_v[w];
        if (dvs_v[w] == '0) begin
          m_ack = cyc + 1; m_start = -1; m_q = '0; m_err = 1;
        end else begin
          m_start = cyc + 1;
          if (div_hang) begin
`ifdef DIV_SCHED_TIMEOUT_EN
            m_ack = cyc + TIMEOUT + 3; m_to = 1;
`else
            m_ack = 32'h7fff_ffff;
`endif
            m_q = '0; m_err = 1;
          end else begin
            m_ack = cyc + DIV_LATENCY + 1;
            m_q = dvd_v[w] / DW'(dvs_v[w]);
            m_err = 0;
          end
        end
      end
      if (m_active && cyc == m_samp + 1) begin
        e_dvd = p_dvd; e_dvs = p_dvs;
      end
      e_busy  = m_active && cyc > m_samp;
      e_start = m_active && cyc == m_start;
      if (m_active && cyc == m_ack) begin
        e_ack[m_w] = 1'b1; e_q = m_q; e_err = m_err;
        if (m_to) m_fault = 1;
      end
    end
    chk("ack", ack, e_ack);
    chk("busy", busy, e_busy);
    chk("div_start", div_start, e_start);
    chk("resp_quotient", resp_quotient, e_q);
    chk("resp_err", resp_err, e_err);
    chk("div_dividend", div_dividend, e_dvd);
    chk("div_divisor", div_divisor, e_dvs);
    chk("fault", fault, m_fault);
    if (!rst && m_active && cyc == m_ack) begin
      m_active = 0; m_last = m_w; m_next = cyc + 2;
    end
  end

  task automatic wait_ack(output int c, output logic [N-1:0] a, input int bound);
    c = -1; a = '0;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        c = cyc; a = ack;
        break;
      end
    end
    if (c < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_wait: no ack within %0d cycles (cycle %0d)", bound, cyc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic drop_and_gap(input int w);
    @(posedge clk); #1 req[w] = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rand_dvd();
    logic [415:0] t;
    for (int j = 0; j < 13; j++) t[j*32 +: 32] = $urandom();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return DW'($urandom_range(0, 100000));
      default: return t[DW-1:0];
    endcase
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int            s, c, prev, got;
    logic [N-1:0]  a, oh, seen;
    logic [DW-1:0] ones_q;
    req = '0;
    for (int i = 0; i < N; i++) begin dvd_v[i] = '0; dvs_v[i] = '0; end

    // Reset state
    @(negedge clk);
    chk("rst_ack", ack, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_quot", resp_quotient, '0);
    chk("rst_dvd", div_dividend, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request: 1000 / 7
    dvd_v[0] = DW'(1000); dvs_v[0] = 8'd7; req[0] = 1'b1; s = cyc;
    wait_ack(c, a, 200);
    chk("t1_lat", c - s, 53);
    chk("t1_ack", a, 4'b0001);
    chk("t1_quot", resp_quotient, DW'(142));
    chk("t1_err", resp_err, 1'b0);
    drop_and_gap(0);

    // All four at once after reset
    do_reset();
    for (int i = 0; i < N; i++) begin dvd_v[i] = rand_dvd(); dvs_v[i] = VW'($urandom_range(1, 255)); end
    req = '1; prev = cyc;
    for (int k = 0; k < N; k++) begin
      wait_ack(c, a, 200);
      oh = '0; oh[k] = 1'b1;
      chk("t2_ack", a, oh);
      chk("t2_lat", c - prev, (k == 0) ? 53 : 55);
      chk("t2_quot", resp_quotient, dvd_v[k] / DW'(dvs_v[k]));
      prev = c;
      @(posedge clk); #1 req[k] = 1'b0;
    end
    @(posedge clk); #1;

    // Divisor zero on requester 2
    dvd_v[2] = rand_dvd(); dvs_v[2] = '0; req[2] = 1'b1; s = cyc; prev = n_start;
    wait_ack(c, a, 200);
    chk("t3_lat", c - s, 1);
    chk("t3_ack", a, 4'b0100);
    chk("t3_err", resp_err, 1'b1);
    chk("t3_quot", resp_quotient, '0);
    drop_and_gap(2);
    chk("t3_nostart", n_start - prev, 0);

    // All-ones dividend / 255
    dvd_v[3] = '1; dvs_v[3] = 8'hFF; req[3] = 1'b1;
    ones_q = {50{8'h01}};
    wait_ack(c, a, 200);
    chk("t4_quot", resp_quotient, ones_q);
    chk("t4_dvd_hold", div_dividend, '1);
    drop_and_gap(3);

    // Reset in the 20th BUSY cycle, then the held request is served afresh
    dvd_v[1] = rand_dvd(); dvs_v[1] = VW'($urandom_range(1, 255)); req[1] = 1'b1; s = cyc;
    while (cyc < s + 21) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", busy, 1'b0);
    chk("t5_ack", ack, '0);
    chk("t5_dvd", div_dividend, '0);
    @(posedge clk); #1 rst = 1'b0; s = cyc;
    wait_ack(c, a, 200);
    chk("t5_lat", c - s, 53);
    chk("t5_ack2", a, 4'b0010);
    drop_and_gap(1);

    // Random traffic
    got = 0;
    for (int t = 0; t < 6000 && got < 40; t++) begin
      @(negedge clk); seen = ack;
      if (ack != '0) got++;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (seen[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 7) == 0) begin
          dvd_v[i] = rand_dvd();
          dvs_v[i] = ($urandom_range(0, 5) == 0) ? '0 : VW'($urandom_range(1, 255));
          req[i] = 1'b1;
        end
      end
    end
    chk("t6_count", got, 40);
    for (int t = 0; t < 2000 && req != '0; t++) begin
      @(negedge clk); seen = ack;
      @(posedge clk); #1 req = req & ~seen;
    end
    chk("t6_drain", req, '0);

`ifdef DIV_SCHED_TIMEOUT_EN
    // Hung divider: watchdog response, then sticky fault blocks grants until reset
    do_reset();
    div_hang = 1'b1;
    dvd_v[0] = DW'(999); dvs_v[0] = 8'd3; req[0] = 1'b1; s = cyc;
    wait_ack(c, a, 400);
    chk("t7_lat", c - s, TIMEOUT + 3);
    chk("t7_err", resp_err, 1'b1);
    chk("t7_quot", resp_quotient, '0);
    chk("t7_fault", fault, 1'b1);
    @(posedge clk); #1 req[0] = 1'b0; req[1] = 1'b1;
    got = 0;
    for (int t = 0; t < 300; t++) begin @(negedge clk); if (ack != '0) got++; end
    chk("t7_noack", got, 0);
    div_hang = 1'b0;
    do_reset();
    @(negedge clk);
    chk("t7_fault_clr", fault, 1'b0);
    wait_ack(c, a, 200);
    chk("t7_ack_after", a, 4'b0010);
    drop_and_gap(1);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
